// File: rtl/systolic_array_ctrl.sv
// Sequencer for an ARRAY_DIM x ARRAY_DIM INT8 systolic array: skewed operand feed, then row-by-row flush.
// DONE pulses START-edge + k_len + 3*ARRAY_DIM; no backpressure, ABORT/RSTn drop any tile in progress.
module systolic_array_ctrl #(
  parameter  int ARRAY_DIM = 4,
  parameter  int K_BWIDTH  = 16,
  localparam int TW        = K_BWIDTH + $clog2(ARRAY_DIM) + 1,
  localparam int RW        = $clog2(ARRAY_DIM)
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 START,
  input  logic [K_BWIDTH-1:0]  K_LEN,
  input  logic                 ABORT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 COMPUTE,
  output logic                 FLUSH,
  output logic [TW-1:0]        FEED_IDX,
  output logic [ARRAY_DIM-1:0] ROW_VALID,
  output logic [ARRAY_DIM-1:0] COL_VALID,
  output logic                 OUT_WE,
  output logic [RW-1:0]        OUT_ROW
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t              state;
  logic [TW-1:0]       t;
  logic [K_BWIDTH-1:0] k_len;
  logic [RW-1:0]       f;
  logic                t_last;

  // Feed ends after k_len + 2*ARRAY_DIM - 1 cycles, so the last t is k_len + 2*ARRAY_DIM - 2.
  assign t_last = (t == (TW'(k_len) + TW'(2 * ARRAY_DIM - 2)));

  // Edge lane i carries element tn-i, which exists only for 0 <= tn-i < kl.
  function automatic logic [ARRAY_DIM-1:0] skew_valid(input logic [TW-1:0] tn,
                                                      input logic [K_BWIDTH-1:0] kl);
    logic [ARRAY_DIM-1:0] v;
    v = '0;
    for (int i = 0; i < ARRAY_DIM; i++) begin
      v[i] = (tn >= TW'(i)) && (tn < (TW'(i) + TW'(kl)));
    end
    return v;
  endfunction

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      t         <= '0;
      k_len     <= '0;
      f         <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      COMPUTE   <= 1'b0;
      FLUSH     <= 1'b0;
      FEED_IDX  <= '0;
      ROW_VALID <= '0;
      COL_VALID <= '0;
      OUT_WE    <= 1'b0;
      OUT_ROW   <= '0;
    end else if (ABORT) begin
      state     <= IDLE;
      t         <= '0;
      f         <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      COMPUTE   <= 1'b0;
      FLUSH     <= 1'b0;
      FEED_IDX  <= '0;
      ROW_VALID <= '0;
      COL_VALID <= '0;
      OUT_WE    <= 1'b0;
      OUT_ROW   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START && (K_LEN != '0)) begin
            state     <= RUN;
            k_len     <= K_LEN;
            t         <= '0;
            BUSY      <= 1'b1;
            COMPUTE   <= 1'b1;
            FEED_IDX  <= '0;
            ROW_VALID <= skew_valid('0, K_LEN);
            COL_VALID <= skew_valid('0, K_LEN);
          end
        end
        RUN: begin
          if (t_last) begin
            state     <= DRAIN;
            f         <= '0;
            COMPUTE   <= 1'b0;
            FLUSH     <= 1'b1;
            OUT_WE    <= 1'b1;
            OUT_ROW   <= '0;
            ROW_VALID <= '0;
            COL_VALID <= '0;
          end else begin
            t         <= t + TW'(1);
            FEED_IDX  <= t + TW'(1);
            ROW_VALID <= skew_valid(t + TW'(1), k_len);
            COL_VALID <= skew_valid(t + TW'(1), k_len);
          end
        end
        DRAIN: begin
          if (f == RW'(ARRAY_DIM - 1)) begin
            state   <= FIN;
            FLUSH   <= 1'b0;
            OUT_WE  <= 1'b0;
            OUT_ROW <= '0;
            DONE    <= 1'b1;
          end else begin
            f       <= f + RW'(1);
            OUT_ROW <= f + RW'(1);
          end
        end
        FIN: begin
          // FEED_IDX keeps the final feed index through FIN and clears on return to IDLE.
          state    <= IDLE;
          t        <= '0;
          BUSY     <= 1'b0;
          DONE     <= 1'b0;
          FEED_IDX <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench: each accepted START expands into a queue of expected per-cycle outputs.
module tb_systolic_array_ctrl;
  localparam int AD = 4;
  localparam int KW = 16;
  localparam int FW = KW + $clog2(AD) + 1;
  localparam int OW = $clog2(AD);

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          START;
  logic [KW-1:0] K_LEN;
  logic          ABORT;
  logic          BUSY, DONE, COMPUTE, FLUSH, OUT_WE;
  logic [FW-1:0] FEED_IDX;
  logic [AD-1:0] ROW_VALID, COL_VALID;
  logic [OW-1:0] OUT_ROW;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          compute;
    logic          flush;
    logic          out_we;
    logic [OW-1:0] out_row;
    logic [AD-1:0] row_v;
    logic [AD-1:0] col_v;
    logic [FW-1:0] feed;
  } obs_t;

  obs_t  q[$];
  logic  last_done = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    cycle  = 0;
  string cur_tag = "idle";

  systolic_array_ctrl #(.ARRAY_DIM(AD), .K_BWIDTH(KW)) dut (
    .CLK(CLK), .RSTn(RSTn), .START(START), .K_LEN(K_LEN), .ABORT(ABORT),
    .BUSY(BUSY), .DONE(DONE), .COMPUTE(COMPUTE), .FLUSH(FLUSH),
    .FEED_IDX(FEED_IDX), .ROW_VALID(ROW_VALID), .COL_VALID(COL_VALID),
    .OUT_WE(OUT_WE), .OUT_ROW(OUT_ROW)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic obs_t sample();
    obs_t o;
    o.busy = BUSY; o.done = DONE; o.compute = COMPUTE; o.flush = FLUSH;
    o.out_we = OUT_WE; o.out_row = OUT_ROW; o.row_v = ROW_VALID;
    o.col_v = COL_VALID; o.feed = FEED_IDX;
    return o;
  endfunction

  task automatic compare(input string tag, input obs_t want);
    obs_t got;
    got = sample();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, got, want);
    end
  endtask

  // Expected trace of one tile, starting with the first RUN cycle.
  task automatic push_tile(input int k);
    obs_t e;
    int   trun;
    trun = k + 2 * AD - 1;
    for (int t = 0; t < trun; t++) begin
      e = '0;
      e.busy = 1'b1; e.compute = 1'b1; e.feed = FW'(t);
      for (int i = 0; i < AD; i++) begin
        e.row_v[i] = (t >= i) && (t < i + k);
        e.col_v[i] = (t >= i) && (t < i + k);
      end
      q.push_back(e);
    end
    for (int f = 0; f < AD; f++) begin
      e = '0;
      e.busy = 1'b1; e.flush = 1'b1; e.out_we = 1'b1;
      e.out_row = OW'(f); e.feed = FW'(trun - 1);
      q.push_back(e);
    end
    e = '0;
    e.busy = 1'b1; e.done = 1'b1; e.feed = FW'(trun - 1);
    q.push_back(e);
  endtask

  task automatic cyc();
    obs_t want;
    @(posedge CLK);
    #1;
    cycle++;
    want = '0;
    if (q.size() != 0) want = q.pop_front();
    last_done = want.done;
    compare(cur_tag, want);
  endtask

  task automatic start_pulse(input int k, input string tag);
    cur_tag = tag;
    START = 1'b1;
    K_LEN = KW'(k);
    if (!ABORT && RSTn && k != 0 && q.size() == 0 && !last_done) push_tile(k);
    cyc();
    START = 1'b0;
    K_LEN = '0;
  endtask

  task automatic drain();
    while (q.size() != 0) cyc();
    cyc();
  endtask

  initial begin
    RSTn = 1'b0; START = 1'b0; K_LEN = '0; ABORT = 1'b0;
    cur_tag = "reset";
    cyc(); cyc();
    RSTn = 1'b1;
    cur_tag = "idle_after_reset";
    cyc();

    // K=3: COMPUTE cycles 1-10, DRAIN 11-14, DONE 15.
    cycle = 0;
    start_pulse(3, "tile_k3");
    drain();

    // K=0 is ignored, then K=1 gives 8 RUN + 4 DRAIN.
    start_pulse(0, "k0_ignored");
    cyc(); cyc();
    start_pulse(1, "tile_k1");
    drain();

    // START with K=9 during RUN cycle 5 changes nothing.
    cycle = 0;
    start_pulse(3, "start_in_run");
    repeat (4) cyc();
    start_pulse(9, "start_in_run");
    drain();

    // START in the FIN cycle is ignored; the next one is accepted.
    start_pulse(2, "start_in_fin");
    while (q.size() != 0 && !last_done) cyc();
    start_pulse(5, "start_in_fin");
    cyc(); cyc();
    start_pulse(1, "after_fin");
    drain();

    // ABORT in DRAIN cycle 12 clears everything without DONE.
    cycle = 0;
    start_pulse(3, "abort_drain");
    repeat (11) cyc();
    ABORT = 1'b1;
    q.delete();
    cur_tag = "abort_drain_idle";
    cyc();
    ABORT = 1'b0;
    cyc();
    start_pulse(3, "after_abort");
    drain();

    // ABORT beats START in IDLE.
    ABORT = 1'b1;
    start_pulse(4, "abort_vs_start");
    ABORT = 1'b0;
    cyc(); cyc();

    // Asynchronous reset mid-RUN clears outputs before any clock edge.
    start_pulse(4, "async_rst_run");
    repeat (3) cyc();
    #2;
    RSTn = 1'b0;
    #1;
    q.delete();
    last_done = 1'b0;
    compare("async_rst_immediate", '0);
    cur_tag = "async_rst_hold";
    cyc();
    RSTn = 1'b1;
    cyc();
    start_pulse(2, "tile_k2_after_rst");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_array_ctrl.md
Name: systolic_array_ctrl

Overview:
Sequencer for an ARRAY_DIM x ARRAY_DIM systolic array of INT8 MAC processing elements.
- Accepts a start request with a reduction length K_LEN.
- Drives the array-wide COMPUTE and FLUSH controls.
- Generates skewed per-row/per-column operand-valid strobes and the operand-buffer read index.
- Sequences the flush of accumulated partial sums out of the array.
- Sits between the host/DMA operand buffers and the PE grid.

Parameters:
ARRAY_DIM, 4, rows = columns of the PE grid (>=2)
K_BWIDTH, 16, width of reduction length and feed index

Ports:
CLK  input  1  clock, rising edge
RSTn  input  1  asynchronous active-low reset
START  input  1  single-cycle request to begin a matrix tile
K_LEN  input  K_BWIDTH  reduction length (operand pairs per PE), sampled with START
ABORT  input  1  synchronous abort, returns to IDLE
BUSY  output  1  tile in progress
DONE  output  1  one-cycle pulse, tile complete
COMPUTE  output  1  array-wide compute enable
FLUSH  output  1  array-wide flush enable
FEED_IDX  output  K_BWIDTH+$clog2(ARRAY_DIM)+1  global feed cycle index t
ROW_VALID  output  ARRAY_DIM  operand-1 valid for left-edge row i
COL_VALID  output  ARRAY_DIM  operand-2 valid for top-edge column j
OUT_WE  output  1  result-row write enable during flush
OUT_ROW  output  $clog2(ARRAY_DIM)  result row index being written

Behaviour:
- Clock and reset: single clock CLK; RSTn asynchronous, active-low.
- While RSTn=0: state=IDLE, counters=0, all outputs 0.
- Reset mid-tile: aborts immediately with no DONE pulse.
- States: IDLE, RUN, DRAIN, FIN. All outputs are registered (Moore).
- IDLE: all outputs 0.
  - START=1 and K_LEN!=0 -> latch k_len=K_LEN, t=0, go to RUN.
  - START with K_LEN==0 is ignored: stay IDLE, no DONE.
- RUN: COMPUTE=1, FLUSH=0, BUSY=1, FEED_IDX=t.
  - Lasts T_RUN = k_len + 2*ARRAY_DIM - 1 cycles (t = 0..T_RUN-1); t increments by 1 per cycle.
  - ROW_VALID[i] = (t >= i) and (t < i + k_len); COL_VALID[j] uses the same rule with j.
  - Skew is one cycle per row/column; operand buffers read element t-i (t-j).
  - On t = T_RUN-1, go to DRAIN with f=0.
- DRAIN: FLUSH=1, COMPUTE=0, BUSY=1, OUT_WE=1, OUT_ROW=f, ROW_VALID/COL_VALID=0, FEED_IDX holds its last value.
  - Lasts exactly ARRAY_DIM cycles (f = 0..ARRAY_DIM-1), then go to FIN.
- FIN: DONE=1 and BUSY=1 for one cycle; COMPUTE, FLUSH and OUT_WE are 0. Next state is IDLE.
- Output invariant: COMPUTE and FLUSH are never 1 in the same cycle.
- Internal counter t width is K_BWIDTH+$clog2(ARRAY_DIM)+1 bits. No wrap occurs for K_LEN = 2^K_BWIDTH-1.
- START while BUSY=1 is ignored; k_len is not re-sampled.
- START in the FIN cycle is also ignored; a new tile is accepted one cycle after DONE.
- ABORT=1 in any state -> next cycle IDLE, all outputs 0, no DONE pulse.
- ABORT and START asserted together in IDLE: ABORT wins, stay IDLE.
- Latency: START accepted at edge n -> first COMPUTE cycle n+1.
  - DONE is high in cycle n + T_RUN + ARRAY_DIM + 1.

Test Plan:
- ARRAY_DIM=4, START with K_LEN=3 at cycle 0: COMPUTE=1 in cycles 1-10, FLUSH=1 and OUT_WE=1 in cycles 11-14 with OUT_ROW 0,1,2,3, DONE=1 only in cycle 15, BUSY=1 in cycles 1-15.
- Same tile, valid strobes: ROW_VALID[0] high for t=0..2, ROW_VALID[3] high for t=3..5, COL_VALID identical; all low for t>=6 and throughout DRAIN.
- START with K_LEN=0: no state change, BUSY/DONE stay 0. A second START with K_LEN=1 gives RUN for 8 cycles, then DRAIN for 4 cycles.
- START pulsed in RUN cycle 5 with K_LEN=9: ignored, tile ends at cycle 15 as in the first scenario.
- ABORT asserted in DRAIN cycle 12: all outputs 0 from cycle 13, no DONE. A new START at cycle 14 is accepted normally.
- RSTn dropped asynchronously mid-RUN: all outputs 0 immediately without waiting for a clock edge. After release, START with K_LEN=2 runs a clean tile (T_RUN=9).
